// File: rtl/chip_vrc4.sv
// chip_vrc4: VRC4-class mapper core (PRG/CHR banking, mirroring, WRAM enable,
// scanline/cycle IRQ counter).
//
// Ports:
//   clk, rst          system clock, asynchronous active-high reset
//   m2_tick           one-clk pulse per CPU cycle
//   wr_stb            one-clk pulse per CPU write, cpu_addr/cpu_data stable
//   cpu_addr/cpu_data CPU bus (A0/A1 already normalised by the wrapper)
//   ppu_addr          PPU A13:A10
//   prg_ce            PRG ROM select (cpu_addr[15])
//   prg_addr          PRG 8 KB bank for the current cpu_addr
//   srm_ce            WRAM select ($6000-$7FFF while WRAM is enabled)
//   chr_addr          CHR 1 KB bank for ppu_addr[12:10]
//   ciram_a10         nametable select
//   irq               level IRQ request, active high
//
// Configuration macro: CHIP_VRC4_IRQ_EN
//   defined   -> IRQ latch/counter/prescaler/control logic is built
//   undefined -> $F000-$F003 writes are ignored and irq is tied low

module chip_vrc4 #(
   parameter int unsigned PRG_BITS = 8,
   parameter int unsigned CHR_BITS = 9
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                m2_tick,
   input  logic                wr_stb,
   input  logic [15:0]         cpu_addr,
   input  logic [7:0]          cpu_data,
   input  logic [3:0]          ppu_addr,
   output logic                prg_ce,
   output logic [PRG_BITS-1:0] prg_addr,
   output logic                srm_ce,
   output logic [CHR_BITS-1:0] chr_addr,
   output logic                ciram_a10,
   output logic                irq
);

   localparam int unsigned CHR_HI_W = CHR_BITS - 4;
   localparam logic [PRG_BITS-1:0] PRG_LAST = '1;
   localparam logic [PRG_BITS-1:0] PRG_PENULT = PRG_LAST - PRG_BITS'(1);

   // Bank / mode registers
   logic [PRG_BITS-1:0] prg0_q, prg0_d, prg1_q, prg1_d;
   logic [1:0]          mirror_q, mirror_d;
   logic                wram_en_q, wram_en_d;
   logic                prg_mode_q, prg_mode_d;
   logic [CHR_BITS-1:0] chr_q [8];
   logic [CHR_BITS-1:0] chr_d [8];

   logic       wr_en;
   logic [1:0] chr_pair;
   logic [2:0] chr_sel;
   logic       unused_addr;

   assign wr_en       = wr_stb & cpu_addr[15];
   // $B000 -> banks 0/1, $C000 -> 2/3, $D000 -> 4/5, $E000 -> 6/7
   assign chr_pair    = 2'(cpu_addr[15:12] - 4'hB);
   assign chr_sel     = {chr_pair, cpu_addr[1]};
   assign unused_addr = ^cpu_addr[11:2];

   // Register-write decode for banking and mode registers
   always_comb begin
      prg0_d     = prg0_q;
      prg1_d     = prg1_q;
      mirror_d   = mirror_q;
      wram_en_d  = wram_en_q;
      prg_mode_d = prg_mode_q;
      chr_d      = chr_q;
      if (wr_en) begin
         case (cpu_addr[15:12])
            4'h8: prg0_d = PRG_BITS'(cpu_data);
            4'hA: prg1_d = PRG_BITS'(cpu_data);
            4'h9: begin
               if (cpu_addr[1]) begin
                  wram_en_d  = cpu_data[0];
                  prg_mode_d = cpu_data[1];
               end else begin
                  mirror_d = cpu_data[1:0];
               end
            end
            4'hB, 4'hC, 4'hD, 4'hE: begin
               if (cpu_addr[0]) chr_d[chr_sel][CHR_BITS-1:4] = CHR_HI_W'(cpu_data);
               else             chr_d[chr_sel][3:0]          = cpu_data[3:0];
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         prg0_q     <= '0;
         prg1_q     <= '0;
         mirror_q   <= '0;
         wram_en_q  <= 1'b0;
         prg_mode_q <= 1'b0;
         for (int i = 0; i < 8; i++) chr_q[i] <= '0;
      end else begin
         prg0_q     <= prg0_d;
         prg1_q     <= prg1_d;
         mirror_q   <= mirror_d;
         wram_en_q  <= wram_en_d;
         prg_mode_q <= prg_mode_d;
         chr_q      <= chr_d;
      end
   end

   // Address outputs, combinational from registers
   always_comb begin
      prg_ce = cpu_addr[15];
      srm_ce = (cpu_addr[15:13] == 3'b011) && wram_en_q;
      case (cpu_addr[14:13])
         2'd0:    prg_addr = prg_mode_q ? PRG_PENULT : prg0_q;
         2'd1:    prg_addr = prg1_q;
         2'd2:    prg_addr = prg_mode_q ? prg0_q : PRG_PENULT;
         default: prg_addr = PRG_LAST;
      endcase
      chr_addr = chr_q[ppu_addr[2:0]];
      case (mirror_q)
         2'd0:    ciram_a10 = ppu_addr[0];
         2'd1:    ciram_a10 = ppu_addr[1];
         2'd2:    ciram_a10 = 1'b0;
         default: ciram_a10 = 1'b1;
      endcase
   end

`ifdef CHIP_VRC4_IRQ_EN
   // Prescaler holds 1..341; subtracting 3 and landing at or below 0 is the
   // same as starting at or below 3, so the wrap adds 341-3 directly.
   localparam int unsigned PRE_W = 9;
   localparam logic [PRE_W-1:0] PRE_RELOAD = 9'd341;
   localparam logic [PRE_W-1:0] PRE_STEP   = 9'd3;
   localparam logic [PRE_W-1:0] PRE_WRAP   = 9'd338;

   logic [7:0]       latch_q, latch_d, cnt_q, cnt_d;
   logic             a_q, a_d, e_q, e_d, m_q, m_d;
   logic [PRE_W-1:0] pre_q, pre_d;
   logic             irq_q, irq_d;
   logic             f_wr, ctrl_wr, cnt_clk;

   assign f_wr    = wr_en && (cpu_addr[15:12] == 4'hF);
   assign ctrl_wr = f_wr && (cpu_addr[1:0] == 2'd2);

   // IRQ control writes, then counting; an overflow set beats an ack clear
   always_comb begin
      latch_d = latch_q;
      cnt_d   = cnt_q;
      a_d     = a_q;
      e_d     = e_q;
      m_d     = m_q;
      pre_d   = pre_q;
      irq_d   = irq_q;
      cnt_clk = 1'b0;
      if (f_wr) begin
         case (cpu_addr[1:0])
            2'd0: latch_d[3:0] = cpu_data[3:0];
            2'd1: latch_d[7:4] = cpu_data[3:0];
            2'd2: begin
               a_d   = cpu_data[0];
               e_d   = cpu_data[1];
               m_d   = cpu_data[2];
               irq_d = 1'b0;
               if (cpu_data[1]) begin
                  cnt_d = latch_q;
                  pre_d = PRE_RELOAD;
               end
            end
            default: begin
               irq_d = 1'b0;
               e_d   = a_q;
            end
         endcase
      end
      // A control write owns the counter for its cycle
      if (e_q && m2_tick && !ctrl_wr) begin
         if (m_q) begin
            cnt_clk = 1'b1;
         end else if (pre_q <= PRE_STEP) begin
            pre_d   = pre_q + PRE_WRAP;
            cnt_clk = 1'b1;
         end else begin
            pre_d = pre_q - PRE_STEP;
         end
      end
      if (cnt_clk) begin
         if (cnt_q == 8'hFF) begin
            cnt_d = latch_q;
            irq_d = 1'b1;
         end else begin
            cnt_d = cnt_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         latch_q <= '0;
         cnt_q   <= '0;
         a_q     <= 1'b0;
         e_q     <= 1'b0;
         m_q     <= 1'b0;
         pre_q   <= PRE_RELOAD;
         irq_q   <= 1'b0;
      end else begin
         latch_q <= latch_d;
         cnt_q   <= cnt_d;
         a_q     <= a_d;
         e_q     <= e_d;
         m_q     <= m_d;
         pre_q   <= pre_d;
         irq_q   <= irq_d;
      end
   end

   assign irq = irq_q;
`else
   logic unused_tick;
   assign unused_tick = m2_tick;
   assign irq         = 1'b0;
`endif

endmodule
